div_iter: RTL and testbench

Iterative 32-bit radix-2 divider that serves as the division engine behind the execute-stage ALU's DIV/DIVU/MOD/MODU ops. It accepts one operand pair with a sign-mode flag through a valid/ready handshake and computes quotient and remainder over 32 iteration cycles. It returns them as a packed 64-bit word through a second valid/ready handshake. The output format places the quotient in [63:32] and the remainder in [31:0], so the ALU result mux consumes it unchanged. A cancel input drops an in-flight operation when the execute stage is flushed.

---
 rtl/div_iter_if.sv | 25 ++
 rtl/div_iter.sv | 117 +++++++++++
 tb/tb_div_iter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// Handshake bundle between the execute-stage ALU and the iterative divider:
// an operand request channel, a result channel and a flush-driven cancel.
interface div_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic        cancel;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  // ALU side: issues operands, consumes results, flushes.
  modport master (
    output in_valid, in_signed, in_dividend, in_divisor, cancel, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Divider side.
  modport slave (
    input  in_valid, in_signed, in_dividend, in_divisor, cancel, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/div_iter.sv
// Iterative 32-bit restoring radix-2 divider for DIV/DIVU/MOD/MODU.
// Operands are converted to magnitudes on accept, 32 shift/trial-subtract
// steps produce |quotient| and |remainder|, and the signs are fixed up on the
// final step so the packed {quotient, remainder} word is registered directly.
module div_iter (
  input  logic      clk,
  input  logic      resetn,
  div_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem;       // partial remainder, always < divisor
  logic [31:0] quo;       // dividend bits shift out the top, quotient bits in
  logic [31:0] divisor;
  logic        q_sign;    // operand signs differ in signed mode
  logic        r_neg;     // signed mode with a negative dividend
  logic        dz;        // divisor was zero
  logic        out_valid;
  logic [63:0] out_data;

  // Magnitudes of the incoming operands (raw in unsigned mode). In signed
  // mode -0x80000000 wraps back to 0x80000000, which is its exact magnitude
  // when read as unsigned.
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  // One restoring step: the shifted remainder needs 33 bits, and the trial
  // subtraction carries one more bit so its borrow tells whether it fits.
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        borrow;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] q_final;
  logic [31:0] r_final;

  // Operand conditioning and the datapath of a single division step.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output
    // up front, so each value is defined on every path and no latch appears.
    a_mag = (bus.in_signed && bus.in_dividend[31]) ? -bus.in_dividend : bus.in_dividend;
    b_mag = (bus.in_signed && bus.in_divisor[31])  ? -bus.in_divisor  : bus.in_divisor;

    shifted          = {rem, quo[31]};
    {borrow, diff}   = {1'b0, shifted} - {2'b00, divisor};
    rem_next         = borrow ? shifted[31:0] : diff[31:0];
    quo_next         = {quo[30:0], ~borrow};

    // A zero divisor leaves quotient all-ones and remainder = |dividend|;
    // only the remainder is re-signed, which restores the original dividend.
    q_final = (q_sign && !dz) ? -quo_next : quo_next;
    r_final = r_neg ? -rem_next : rem_next;
  end

  // Control FSM plus all datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state is updated with non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      q_sign    <= 1'b0;
      r_neg     <= 1'b0;
      dz        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (bus.cancel) begin
      // A flush wins over accept and over the result handshake; out_data
      // keeps its stale value since it is only meaningful with out_valid.
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            quo     <= a_mag;
            divisor <= b_mag;
            rem     <= '0;
            cnt     <= '0;
            q_sign  <= bus.in_signed && (bus.in_dividend[31] ^ bus.in_divisor[31]);
            r_neg   <= bus.in_signed && bus.in_dividend[31];
            dz      <= (bus.in_divisor == 32'h0);
            state   <= CALC;
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            out_data  <= {q_final, r_final};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases, handshake,
// cancel and async-reset behaviour, then a randomized sweep against an
// arithmetic reference model.
module tb_div_iter;

  logic clk;
  logic resetn;

  div_iter_if bus ();

  div_iter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain SV arithmetic (truncating division, remainder takes
  // the dividend's sign) plus the divide-by-zero and overflow rules.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'h0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'h0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Present operands at a falling edge and let the next rising edge accept.
  task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid    = 1'b1;
    bus.in_signed   = s;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    check("in_ready_idle", {63'h0, bus.in_ready}, 64'h1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("in_ready_busy", {63'h0, bus.in_ready}, 64'h0);
  endtask

  // Count falling edges from the one after the accept edge until out_valid.
  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    if (!bus.out_valid) check({tag, "_timeout"}, 64'h0, 64'h1);
  endtask

  task automatic finish_op(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, {63'h0, bus.out_valid}, 64'h0);
    check({tag, "_ready_back"}, {63'h0, bus.in_ready}, 64'h1);
  endtask

  task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int cyc;
    start_op(s, a, b);
    wait_valid(tag, cyc);
    check({tag, "_latency"}, 64'(cyc), 64'd32);
    check(tag, bus.out_data, exp);
    finish_op(tag);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    bit seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check(tag, {63'h0, seen}, 64'h0);
  endtask

  int          cyc;
  logic [63:0] exp_v;
  logic [31:0] ra;
  logic [31:0] rb;
  bit          rs;

  initial begin
    resetn          = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_signed   = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.cancel      = 1'b0;
    bus.out_ready   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready",  {63'h0, bus.in_ready},  64'h1);
    check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rst_out_data",  bus.out_data,           64'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed values.
    run_op("u_7_2",      1'b0, 32'd7,          32'd2,          64'h00000003_00000001);
    run_op("s_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFD_FFFFFFFF);
    run_op("s_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  64'hFFFFFFFD_00000001);
    run_op("u_fff9_2",   1'b0, 32'hFFFF_FFF9,  32'd2,          64'h7FFFFFFC_00000001);
    run_op("s_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h80000000_00000000);
    run_op("s_dz",       1'b1, 32'h1234_5678,  32'h0,          64'hFFFFFFFF_12345678);
    run_op("u_dz",       1'b0, 32'h1234_5678,  32'h0,          64'hFFFFFFFF_12345678);
    run_op("s_dz_neg",   1'b1, 32'h8765_4321,  32'h0,          64'hFFFFFFFF_87654321);
    run_op("u_8000_1",   1'b0, 32'h8000_0000,  32'd1,          64'h80000000_00000000);
    run_op("u_max_max",  1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000001_00000000);

    // Backpressure: result held, no accepts while waiting.
    exp_v = ref_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_valid("bp", cyc);
    repeat (10) begin
      bus.in_valid    = 1'b1;
      bus.in_dividend = $urandom;
      bus.in_divisor  = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("bp_valid",    {63'h0, bus.out_valid}, 64'h1);
      check("bp_data",     bus.out_data,           exp_v);
      check("bp_in_ready", {63'h0, bus.in_ready},  64'h0);
    end
    bus.in_valid = 1'b0;
    finish_op("bp");
    run_op("bp_next", 1'b0, 32'd1000, 32'd33, 64'h0000001E_0000000A);

    // Cancel mid-calculation.
    start_op(1'b0, 32'd12345, 32'd11);
    repeat (14) @(negedge clk);
    bus.cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_calc_idle",  {63'h0, bus.in_ready},  64'h1);
    check("cancel_calc_valid", {63'h0, bus.out_valid}, 64'h0);
    expect_quiet("cancel_calc_quiet", 40);

    // Cancel together with in_valid in IDLE: no accept.
    bus.in_valid    = 1'b1;
    bus.cancel      = 1'b1;
    bus.in_dividend = 32'd50;
    bus.in_divisor  = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cancel   = 1'b0;
    check("cancel_idle_ready", {63'h0, bus.in_ready}, 64'h1);
    expect_quiet("cancel_idle_quiet", 40);

    // Cancel in DONE while the consumer is stalled.
    start_op(1'b0, 32'd50, 32'd5);
    wait_valid("cancel_done", cyc);
    bus.cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_done_valid", {63'h0, bus.out_valid}, 64'h0);
    check("cancel_done_ready", {63'h0, bus.in_ready},  64'h1);
    run_op("after_cancel", 1'b1, 32'hFFFF_FF9C, 32'd7, ref_div(1'b1, 32'hFFFF_FF9C, 32'd7));

    // Asynchronous reset between clock edges mid-calculation.
    start_op(1'b0, 32'hFFFF_0000, 32'd3);
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_in_ready",  {63'h0, bus.in_ready},  64'h1);
    check("arst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("arst_out_data",  bus.out_data,           64'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op("arst_100_7", 1'b0, 32'd100, 32'd7, 64'h0000000E_00000002);

    // Randomized sweep against the reference model.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = (i % 9 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op("rand", rs, ra, rb, ref_div(rs, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
